// File: rtl/internal_reconfig_pkg.sv
// Shared types and helpers for the internal-reconfiguration controller.
// Pure declarations: no latency, no backpressure.
package internal_reconfig_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT, ERR} state_e;

  localparam logic [3:0] LED_OFF = 4'b0000;
  localparam logic [3:0] LED_ALL = 4'b1111;
  localparam logic [3:0] LED_HB  = 4'b1000;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int clog2_safe(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int last_idx(input int cyc);
    return (cyc > 0) ? cyc - 1 : 0;
  endfunction

endpackage

// File: rtl/reconfig_debounce.sv
// 2-FF synchroniser plus debouncer with a 1-cycle rising-edge pulse.
// Raw edge to pulse: 2+DEBOUNCE_CYC+1 cycles; no backpressure.
module reconfig_debounce
  import internal_reconfig_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int               CNT_W    = clog2_safe(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(last_idx(DEBOUNCE_CYC));

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q, rise_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/internal_reconfig_ctrl.sv
// Selects a flash image from debounced buttons and runs the ENA/CBSEL/CONFIG reconfig sequence.
// All outputs registered (state change on cycle N visible at N+1); no backpressure.
module internal_reconfig_ctrl
  import internal_reconfig_pkg::*;
#(
  parameter int SEL_W            = 2,
  parameter int NUM_IMAGES       = 4,
  parameter int DEBOUNCE_CYC     = 100000,
  parameter int ENA_SETUP_CYC    = 16,
  parameter int CONFIG_PULSE_CYC = 8,
  parameter int WDOG_CYC         = 1000000,
  parameter int BLINK_DIV        = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_next,
  input  logic             reverse,
  input  logic             btn_go,
  input  logic             cfg_ERROR,
  output logic             cfg_ENA,
  output logic             cfg_CONFIG,
  output logic [SEL_W-1:0] cfg_CBSEL,
  output logic             cfg_ERROR_port,
  output logic [3:0]       led,
  output logic             busy
);

  localparam int SEQ_MAX = (ENA_SETUP_CYC > CONFIG_PULSE_CYC) ? ENA_SETUP_CYC : CONFIG_PULSE_CYC;
  localparam int SEQ_W   = clog2_safe(SEQ_MAX);
  localparam int WDOG_W  = clog2_safe(WDOG_CYC);
  localparam int BLINK_W = clog2_safe(BLINK_DIV);

  localparam logic [SEQ_W-1:0]   SETUP_LAST = SEQ_W'(last_idx(ENA_SETUP_CYC));
  localparam logic [SEQ_W-1:0]   PULSE_LAST = SEQ_W'(last_idx(CONFIG_PULSE_CYC));
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(last_idx(WDOG_CYC));
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(last_idx(BLINK_DIV));
  localparam logic [SEL_W-1:0]   IMG_LAST   = SEL_W'(NUM_IMAGES - 1);

  logic next_pulse, go_pulse, rev_lvl;
  logic next_lvl, go_lvl, rev_rise;
  logic unused_dbg;

  reconfig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk(clk), .rst(rst), .raw_i(btn_next), .level_o(next_lvl), .rise_o(next_pulse)
  );
  reconfig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_go (
    .clk(clk), .rst(rst), .raw_i(btn_go), .level_o(go_lvl), .rise_o(go_pulse)
  );
  reconfig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_rev (
    .clk(clk), .rst(rst), .raw_i(reverse), .level_o(rev_lvl), .rise_o(rev_rise)
  );

  assign unused_dbg = next_lvl ^ go_lvl ^ rev_rise;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, cbsel_q, cbsel_d, disp_sel;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               err_s1_q, err_s2_q;
  logic               ena_q, config_q, err_port_q, busy_q;
  logic [3:0]         led_q, led_d, sel_disp;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cbsel_d   = cbsel_q;
    seq_cnt_d = seq_cnt_q;
    wdog_d    = wdog_q;
    case (state_q)
      IDLE: begin
        // go wins over a coincident next, so the image being launched is never perturbed
        if (go_pulse) begin
          state_d   = SETUP;
          cbsel_d   = sel_q;
          seq_cnt_d = '0;
        end else if (next_pulse) begin
          if (rev_lvl) sel_d = (sel_q == '0) ? IMG_LAST : sel_q - SEL_W'(1);
          else         sel_d = (sel_q >= IMG_LAST) ? '0 : sel_q + SEL_W'(1);
        end
      end
      SETUP: begin
        if (err_s2_q) begin
          state_d = ERR;
        end else if (seq_cnt_q >= SETUP_LAST) begin
          state_d   = PULSE;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      PULSE: begin
        if (err_s2_q) begin
          state_d = ERR;
        end else if (seq_cnt_q >= PULSE_LAST) begin
          state_d = WAIT;
          wdog_d  = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      WAIT: begin
        if (err_s2_q || (wdog_q >= WDOG_LAST)) state_d = ERR;
        else                                   wdog_d  = wdog_q + WDOG_W'(1);
      end
      ERR: begin
        if (go_pulse) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d == IDLE) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q >= BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  assign disp_sel = (state_d == IDLE) ? sel_d : cbsel_d;

  generate
    if (SEL_W >= 4) begin : g_disp_wide
      assign sel_disp = disp_sel[3:0];
    end else begin : g_disp_narrow
      assign sel_disp = {{(4-SEL_W){1'b0}}, disp_sel};
    end
  endgenerate

  always_comb begin
    led_d = sel_disp;
    case (state_d)
      IDLE:    led_d = sel_disp;
      ERR:     led_d = blink_q ? LED_ALL : LED_OFF;
      default: led_d = (sel_disp & ~LED_HB) | (blink_q ? LED_HB : LED_OFF);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cbsel_q     <= '0;
      seq_cnt_q   <= '0;
      wdog_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      err_s1_q    <= 1'b0;
      err_s2_q    <= 1'b0;
      ena_q       <= 1'b0;
      config_q    <= 1'b0;
      err_port_q  <= 1'b0;
      busy_q      <= 1'b0;
      led_q       <= LED_OFF;
    end else begin
      err_s1_q    <= cfg_ERROR;
      err_s2_q    <= err_s1_q;
      state_q     <= state_d;
      sel_q       <= sel_d;
      cbsel_q     <= cbsel_d;
      seq_cnt_q   <= seq_cnt_d;
      wdog_q      <= wdog_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      // Outputs decode the next state so they line up with state_q.
      ena_q       <= (state_d == SETUP) || (state_d == PULSE) || (state_d == WAIT);
      config_q    <= (state_d == PULSE);
      err_port_q  <= (state_d == ERR);
      busy_q      <= (state_d != IDLE);
      led_q       <= led_d;
    end
  end

  assign cfg_ENA        = ena_q;
  assign cfg_CONFIG     = config_q;
  assign cfg_CBSEL      = cbsel_q;
  assign cfg_ERROR_port = err_port_q;
  assign led            = led_q;
  assign busy           = busy_q;

endmodule
